rx_frame_ctrl: RTL and testbench
================================

RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

Interface
REQ-001 SHALL provide parameter OVS, default 16, srClock cycles per serial bit (power of two, 8..32).
REQ-002 SHALL provide parameter DONE_TMO, default 32, srClock cycles allowed in WAIT_DONE for charRec.
REQ-003 SHALL have srClock, input, 1, the only clock; all flops rise on srClock.
REQ-004 SHALL have rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have serIn, input, 1, raw asynchronous serial line; idles high.
REQ-006 SHALL have charRec, input, 1, one-cycle frame-complete pulse from bicReceive.
REQ-007 SHALL have recEn, output, 1, receive enable to bicReceive.
REQ-008 SHALL have rxData, output, 8, last accepted character.
REQ-009 SHALL have rxValid, output, 1, one-cycle pulse when rxData updates.
REQ-010 SHALL have frameErr, output, 1, one-cycle pulse on bad stop bit or charRec timeout.

Function
REQ-011 SHALL pass serIn through a 2-flop synchronizer; sIn is the second flop; both flops reset to 1.
REQ-012 SHALL implement states IDLE, START_CHK, RECV, WAIT_DONE; recEn = 1 in all states except IDLE, registered.
REQ-013 IDLE: on the first edge sampling sIn == 0, SHALL enter START_CHK with phase counter cleared to 0.
REQ-014 START_CHK: phase counts 0..OVS/2-1; at OVS/2-1, sIn == 1 -> IDLE (false start, no pulses); sIn == 0 -> RECV, phase = 0, bitIdx = 0.
REQ-015 RECV: phase counts 0..OVS-1 and wraps; at OVS-1, sIn is sampled into bit bitIdx; bitIdx 0..7 are data, LSB first; bitIdx 8 is stop.
REQ-016 Data bits SHALL be shifted into an internal 8-bit register; rxData SHALL NOT change before acceptance (REQ-018).
REQ-017 After the stop sample, SHALL store stopOk = sIn and enter WAIT_DONE with the timeout counter at 0.
REQ-018 WAIT_DONE: on charRec == 1 and stopOk == 1, SHALL load rxData, pulse rxValid on the next cycle, and go to IDLE.
REQ-019 WAIT_DONE: on charRec == 1 and stopOk == 0, SHALL pulse frameErr, leave rxData unchanged, and go to IDLE.
REQ-020 WAIT_DONE: if DONE_TMO cycles elapse without charRec, SHALL pulse frameErr and go to IDLE; rxData stays unchanged.
REQ-021 charRec SHALL be ignored in IDLE, START_CHK and RECV.
REQ-022 recEn SHALL fall on the same edge that enters IDLE; rxValid and frameErr SHALL never assert together.
REQ-023 A new start bit SHALL be accepted on the first IDLE cycle after a frame (no dead time beyond REQ-013).
REQ-024 Nominal latency: sIn low at edge E -> recEn high after E+1; rxValid is one cycle after the charRec edge.
REQ-025 Counters SHALL be sized from OVS ($clog2) and DONE_TMO; no counter SHALL wrap beyond its terminal value.

Reset
REQ-026 rst SHALL force IDLE, recEn = 0, rxData = 8'h00, rxValid = 0, frameErr = 0, synchronizer = 1, and all counters to 0.
REQ-027 rst asserted mid-frame SHALL abort the frame with no pulse; after release, a frame SHALL be received only after serIn first returns high and then falls.

Verification
REQ-028 Frame 0x41 (start 0, bits 1000_0010 LSB-first, stop 1) at OVS cycles per bit, charRec pulsed 1 cycle after the stop sample -> rxData = 8'h41, one rxValid pulse, recEn low the same edge.
REQ-029 serIn low for 3 cycles, then high -> recEn high for exactly OVS/2 cycles, then low; no rxValid or frameErr; rxData unchanged.
REQ-030 Frame 0x5A with stop bit 0 plus charRec -> one frameErr pulse, no rxValid, rxData keeps its prior value.
REQ-031 Valid frame 0x33 with charRec withheld -> frameErr exactly DONE_TMO cycles after WAIT_DONE entry, recEn low on the same edge.
REQ-032 rst pulse during data bit 4 of a frame -> all outputs return to reset values; the next clean frame 0x7E is received correctly.
REQ-033 Back-to-back frames 0x01 then 0xFF, with the second start bit immediately after charRec -> two rxValid pulses carrying 8'h01 then 8'hFF.

Source files
------------

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: oversampled start/data/stop framing for the serial receive path.
// Detects and qualifies a start bit, samples 8 data bits LSB first plus the stop bit,
// then waits for bicReceive to confirm the frame with charRec before publishing it.
//
// Handshake: charRec is a one-cycle completion pulse that is only acted on in
// WAIT_DONE. Each accepted frame produces exactly one rxValid pulse, in the cycle
// after charRec, with rxData already updated. A rejected frame produces one frameErr
// pulse instead. The two pulses are mutually exclusive.
module rx_frame_ctrl #(
    parameter int OVS      = 16,
    parameter int DONE_TMO = 32
) (
    input  logic       srClock,
    input  logic       rst,
    input  logic       serIn,
    input  logic       charRec,
    output logic       recEn,
    output logic [7:0] rxData,
    output logic       rxValid,
    output logic       frameErr,
    output logic [1:0] dbgState
);

    localparam int PW = $clog2(OVS);
    localparam int TW = $clog2(DONE_TMO + 1);

    localparam logic [PW-1:0] HALF_LAST = PW'(OVS / 2 - 1);
    localparam logic [PW-1:0] PH_LAST   = PW'(OVS - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(DONE_TMO - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_CHK = 2'd1,
        RECV      = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t        state;
    logic          s1;
    logic          sIn;
    logic          vld1;
    logic          vld2;
    logic          armed;
    logic [PW-1:0] phase;
    logic [3:0]    bitIdx;
    logic [TW-1:0] tmo;
    logic [7:0]    shreg;
    logic          stopOk;

    assign dbgState = state;

    // Two-flop synchronizer, plus an arming flag: after reset, sIn only becomes
    // trustworthy two edges later, and the line must be seen high once before a
    // falling edge may count as a start bit.
    always_ff @(posedge srClock or posedge rst) begin
        if (rst) begin
            s1    <= 1'b1;
            sIn   <= 1'b1;
            vld1  <= 1'b0;
            vld2  <= 1'b0;
            armed <= 1'b0;
        end else begin
            s1   <= serIn;
            sIn  <= s1;
            vld1 <= 1'b1;
            vld2 <= vld1;
            if (vld2 && sIn) begin
                armed <= 1'b1;
            end
        end
    end

    // Frame FSM with registered recEn/rxData/rxValid/frameErr.
    always_ff @(posedge srClock or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            recEn    <= 1'b0;
            rxData   <= 8'h00;
            rxValid  <= 1'b0;
            frameErr <= 1'b0;
            phase    <= '0;
            bitIdx   <= '0;
            tmo      <= '0;
            shreg    <= 8'h00;
            stopOk   <= 1'b0;
        end else begin
            rxValid  <= 1'b0;
            frameErr <= 1'b0;
            case (state)
                IDLE: begin
                    phase <= '0;
                    tmo   <= '0;
                    if (armed && !sIn) begin
                        state <= START_CHK;
                        recEn <= 1'b1;
                    end
                end

                START_CHK: begin
                    // Re-check the line half a bit later to reject glitches.
                    if (phase == HALF_LAST) begin
                        phase <= '0;
                        if (sIn) begin
                            state <= IDLE;
                            recEn <= 1'b0;
                        end else begin
                            state  <= RECV;
                            bitIdx <= '0;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end

                RECV: begin
                    if (phase == PH_LAST) begin
                        phase <= '0;
                        if (bitIdx == 4'd8) begin
                            stopOk <= sIn;
                            tmo    <= '0;
                            state  <= WAIT_DONE;
                        end else begin
                            // LSB arrives first, so shift in from the top.
                            shreg  <= {sIn, shreg[7:1]};
                            bitIdx <= bitIdx + 1'b1;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end

                WAIT_DONE: begin
                    if (charRec) begin
                        if (stopOk) begin
                            rxData  <= shreg;
                            rxValid <= 1'b1;
                        end else begin
                            frameErr <= 1'b1;
                        end
                        state <= IDLE;
                        recEn <= 1'b0;
                        tmo   <= '0;
                    end else if (tmo == TMO_LAST) begin
                        frameErr <= 1'b1;
                        state    <= IDLE;
                        recEn    <= 1'b0;
                        tmo      <= '0;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    recEn <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl: directed frames against rx_frame_ctrl with hand-derived timing.
// Frame timing, counted in edges after the edge preceding the first low drive:
// start seen at edge 3, midpoint at 11, data bit i sampled at 27+16*i, stop at 155.
module tb_rx_frame_ctrl;

    localparam int OVS      = 16;
    localparam int DONE_TMO = 32;

    logic       srClock = 1'b0;
    logic       rst;
    logic       serIn;
    logic       charRec;
    logic       recEn;
    logic [7:0] rxData;
    logic       rxValid;
    logic       frameErr;
    logic [1:0] dbgState;

    int errors = 0;
    int checks = 0;
    int rv_cnt = 0;
    int fe_cnt = 0;
    logic [7:0] exp_q[$];

    rx_frame_ctrl #(.OVS(OVS), .DONE_TMO(DONE_TMO)) dut (
        .srClock (srClock),
        .rst     (rst),
        .serIn   (serIn),
        .charRec (charRec),
        .recEn   (recEn),
        .rxData  (rxData),
        .rxValid (rxValid),
        .frameErr(frameErr),
        .dbgState(dbgState)
    );

    // Clock
    always #5 srClock = ~srClock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every rxValid pulse must match the next expected byte.
    always @(negedge srClock) begin
        if (!rst) begin
            if (rxValid || frameErr) begin
                check("pulse_excl", {31'd0, rxValid & frameErr}, 32'd0);
            end
            if (rxValid) begin
                rv_cnt++;
                check("rx_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    check("rx_data_sb", {24'd0, rxData}, {24'd0, exp_q.pop_front()});
                end
            end
            if (frameErr) begin
                fe_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge srClock);
        #1;
    endtask

    // Drive one frame starting now (just after an edge) for n cycles.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int n,
                              input int rec_at, input int spur_at);
        int seg;
        for (int c = 0; c < n; c++) begin
            if (c == 2) check("recEn_pre", {31'd0, recEn}, 32'd0);
            if (c == 3) check("recEn_rise", {31'd0, recEn}, 32'd1);
            seg = c / OVS;
            if (seg == 0) serIn = 1'b0;
            else if (seg <= 8) serIn = d[seg-1];
            else serIn = (c < 9 * OVS + 10) ? stop : 1'b1;
            charRec = (c == rec_at) || (c == spur_at);
            tick();
        end
        charRec = 1'b0;
        serIn   = 1'b1;
    endtask

    initial begin
        int cnt;
        int fire;
        logic en_fire;
        logic en_prev;
        logic prev;

        rst = 1'b1;
        serIn = 1'b1;
        charRec = 1'b0;
        repeat (3) tick();
        check("rst_recEn", {31'd0, recEn}, 32'd0);
        check("rst_rxData", {24'd0, rxData}, 32'h00);
        check("rst_rxValid", {31'd0, rxValid}, 32'd0);
        check("rst_frameErr", {31'd0, frameErr}, 32'd0);
        check("rst_state", {30'd0, dbgState}, 32'd0);
        rst = 1'b0;
        repeat (5) tick();

        // Frame 0x41, stray charRec during RECV, confirm right after stop sample.
        exp_q.push_back(8'h41);
        send_frame(8'h41, 1'b1, 156, 155, 80);
        check("f41_rxValid", {31'd0, rxValid}, 32'd1);
        check("f41_rxData", {24'd0, rxData}, 32'h41);
        check("f41_recEn_low", {31'd0, recEn}, 32'd0);
        check("f41_frameErr", {31'd0, frameErr}, 32'd0);
        tick();
        check("f41_rxValid_1cyc", {31'd0, rxValid}, 32'd0);
        check("f41_rv_cnt", rv_cnt, 32'd1);

        // False start: 3 low cycles.
        repeat (5) tick();
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (recEn) cnt++;
            serIn = (c < 3) ? 1'b0 : 1'b1;
            tick();
        end
        check("false_recEn_cycles", cnt, OVS / 2);
        check("false_rv_cnt", rv_cnt, 32'd1);
        check("false_fe_cnt", fe_cnt, 32'd0);
        check("false_rxData", {24'd0, rxData}, 32'h41);

        // Frame 0x5A with a bad stop bit.
        send_frame(8'h5A, 1'b0, 156, 155, -1);
        check("bad_stop_frameErr", {31'd0, frameErr}, 32'd1);
        check("bad_stop_rxValid", {31'd0, rxValid}, 32'd0);
        check("bad_stop_rxData", {24'd0, rxData}, 32'h41);
        check("bad_stop_recEn", {31'd0, recEn}, 32'd0);
        repeat (2) tick();
        check("bad_stop_fe_cnt", fe_cnt, 32'd1);
        check("bad_stop_rv_cnt", rv_cnt, 32'd1);

        // Frame 0x33, charRec withheld: timeout DONE_TMO cycles after WAIT_DONE entry.
        send_frame(8'h33, 1'b1, 155, -1, -1);
        check("tmo_entry_state", {30'd0, dbgState}, 32'd3);
        fire = -1;
        en_fire = 1'b0;
        en_prev = 1'b0;
        prev = recEn;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (fire < 0 && frameErr) begin
                fire = k;
                en_fire = recEn;
                en_prev = prev;
            end
            prev = recEn;
        end
        check("tmo_cycles", fire, DONE_TMO);
        check("tmo_recEn_low", {31'd0, en_fire}, 32'd0);
        check("tmo_recEn_before", {31'd0, en_prev}, 32'd1);
        check("tmo_rxData", {24'd0, rxData}, 32'h41);
        check("tmo_fe_cnt", fe_cnt, 32'd2);

        // Reset during data bit 4 (line low), line held low after release.
        send_frame(8'h0F, 1'b1, 88, -1, -1);
        serIn = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_recEn", {31'd0, recEn}, 32'd0);
        check("midrst_rxData", {24'd0, rxData}, 32'h00);
        check("midrst_rxValid", {31'd0, rxValid}, 32'd0);
        check("midrst_frameErr", {31'd0, frameErr}, 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (recEn) cnt++;
        end
        check("midrst_low_line_no_start", cnt, 32'd0);
        serIn = 1'b1;
        repeat (20) tick();
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, 156, 155, -1);
        check("f7e_rxValid", {31'd0, rxValid}, 32'd1);
        check("f7e_rxData", {24'd0, rxData}, 32'h7E);
        check("midrst_fe_cnt", fe_cnt, 32'd2);

        // Back-to-back 0x01 then 0xFF, second start right after charRec.
        repeat (4) tick();
        exp_q.push_back(8'h01);
        exp_q.push_back(8'hFF);
        send_frame(8'h01, 1'b1, 156, 155, -1);
        check("b2b_first_rxData", {24'd0, rxData}, 32'h01);
        check("b2b_first_rxValid", {31'd0, rxValid}, 32'd1);
        send_frame(8'hFF, 1'b1, 156, 155, -1);
        check("b2b_second_rxData", {24'd0, rxData}, 32'hFF);
        check("b2b_second_rxValid", {31'd0, rxValid}, 32'd1);
        repeat (3) tick();
        check("final_rv_cnt", rv_cnt, 32'd4);
        check("final_fe_cnt", fe_cnt, 32'd2);
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
